// File: rtl/pulse_detect.sv
// Synchronizes an asynchronous level pulse, rejects short glitches, strobes once per
// qualified pulse and reports its saturating high-time after a minimum low gap.
module pulse_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 4,
  parameter int unsigned MIN_LOW     = 4,
  parameter int unsigned CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             pulse_out,
  output logic             glitch,
  output logic [CNT_W-1:0] width,
  output logic             width_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] HIGH_TGT = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] LOW_TGT  = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    ACTIVE  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0]       lcnt, lcnt_nxt, lcnt_inc;
  logic [CNT_W-1:0]       width_nxt;
  logic                   pulse_nxt, glitch_nxt, vld_nxt;

  // Metastability chain; only the last stage feeds the FSM
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = cnt + CNT_ONE;
  assign lcnt_inc = lcnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lcnt      <= '0;
      width     <= '0;
      pulse_out <= 1'b0;
      glitch    <= 1'b0;
      width_vld <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lcnt      <= lcnt_nxt;
      width     <= width_nxt;
      pulse_out <= pulse_nxt;
      glitch    <= glitch_nxt;
      width_vld <= vld_nxt;
    end
  end

  // Next-state and strobe decode; strobes are one-hot by construction of the state arcs
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lcnt_nxt   = lcnt;
    width_nxt  = width;
    pulse_nxt  = 1'b0;
    glitch_nxt = 1'b0;
    vld_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          cnt_nxt = CNT_ONE;
          if (MIN_HIGH == 1) begin
            pulse_nxt = 1'b1;
            state_nxt = ACTIVE;
          end else begin
            state_nxt = QUAL;
          end
        end
      end
      QUAL: begin
        if (s) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == HIGH_TGT) begin
            pulse_nxt = 1'b1;
            state_nxt = ACTIVE;
          end
        end else begin
          glitch_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      ACTIVE: begin
        if (s) begin
          if (cnt != CNT_MAX) cnt_nxt = cnt_inc;
        end else begin
          width_nxt = cnt;
          vld_nxt   = 1'b1;
          lcnt_nxt  = CNT_ONE;
          state_nxt = (MIN_LOW == 1) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        // A bounce restarts the low-gap count without reporting anything
        if (s) begin
          lcnt_nxt = '0;
        end else begin
          lcnt_nxt = lcnt_inc;
          if (lcnt_inc == LOW_TGT) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pulse_detect.sv
// Directed scenarios plus randomized run-length stimulus against a run-counting reference model.
module tb_pulse_detect;

  localparam int unsigned SS    = 2;
  localparam int unsigned MH    = 4;
  localparam int unsigned ML    = 4;
  localparam int unsigned CW    = 10;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig_in;
  logic          pulse_out, glitch, width_vld;
  logic [CW-1:0] width;

  pulse_detect #(.SYNC_STAGES(SS), .MIN_HIGH(MH), .MIN_LOW(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .pulse_out(pulse_out),
    .glitch(glitch), .width(width), .width_vld(width_vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history delayed by the synchronizer, high-run length and low-gap length
  bit hist[SS];
  int hi_run;
  int gap_run;
  bit in_gap;
  bit exp_pulse, exp_glitch, exp_vld;
  int exp_width;

  task automatic model_reset();
    for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    hi_run = 0; gap_run = 0; in_gap = 1'b0;
    exp_pulse = 1'b0; exp_glitch = 1'b0; exp_vld = 1'b0; exp_width = 0;
  endtask

  task automatic model_step(input bit v);
    bit s;
    s = hist[SS-1];
    exp_pulse = 1'b0; exp_glitch = 1'b0; exp_vld = 1'b0;
    if (in_gap) begin
      if (s) gap_run = 0;
      else begin
        gap_run++;
        if (gap_run >= ML) in_gap = 1'b0;
      end
    end else if (s) begin
      hi_run++;
      if (hi_run == MH) exp_pulse = 1'b1;
    end else if (hi_run > 0) begin
      if (hi_run < MH) exp_glitch = 1'b1;
      else begin
        exp_vld   = 1'b1;
        exp_width = (hi_run > CMAX) ? CMAX : hi_run;
        gap_run   = 1;
        in_gap    = (ML > 1);
      end
      hi_run = 0;
    end
    for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endtask

  int cyc = 0;
  int n_pulse, n_glitch, n_vld;
  int last_pulse_cyc, last_glitch_cyc, last_vld_cyc, last_width;

  task automatic clear_counts();
    n_pulse = 0; n_glitch = 0; n_vld = 0;
  endtask

  // Drive one clock worth of input, advance the model, then check after the edge
  task automatic cycle(input bit v, input bit r);
    sig_in = v;
    rst    = r;
    if (r) model_reset();
    else   model_step(v);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("pulse_out", int'(pulse_out), int'(exp_pulse));
    check("glitch", int'(glitch), int'(exp_glitch));
    check("width_vld", int'(width_vld), int'(exp_vld));
    check("width", int'(width), exp_width);
    check("exclusive", int'((int'(pulse_out) + int'(glitch) + int'(width_vld)) > 1), 0);
    if (pulse_out === 1'b1) begin n_pulse++; last_pulse_cyc = cyc; end
    if (glitch === 1'b1)    begin n_glitch++; last_glitch_cyc = cyc; end
    if (width_vld === 1'b1) begin n_vld++; last_vld_cyc = cyc; last_width = int'(width); end
  endtask

  task automatic run(input bit v, input int n);
    for (int i = 0; i < n; i++) cycle(v, 1'b0);
  endtask

  int t0;
  bit lvl;

  initial begin
    rst = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    check("reset_width", int'(width), 0);
    run(1'b0, 5);

    // Nominal pulse
    clear_counts();
    t0 = cyc; run(1'b1, 20);
    check("nom_rise_lat", last_pulse_cyc - t0, 6);
    t0 = cyc; run(1'b0, 15);
    check("nom_fall_lat", last_vld_cyc - t0, 3);
    check("nom_pulses", n_pulse, 1);
    check("nom_vld", n_vld, 1);
    check("nom_width", last_width, 20);

    // Glitch
    clear_counts();
    run(1'b1, 3);
    t0 = cyc; run(1'b0, 15);
    check("gl_lat", last_glitch_cyc - t0, 3);
    check("gl_count", n_glitch, 1);
    check("gl_pulses", n_pulse + n_vld, 0);
    check("gl_width_kept", int'(width), 20);

    // Saturation
    clear_counts();
    run(1'b1, 2000); run(1'b0, 15);
    check("sat_pulses", n_pulse, 1);
    check("sat_vld", n_vld, 1);
    check("sat_width", last_width, 1023);

    // Bounce during holdoff
    clear_counts();
    run(1'b1, 10); run(1'b0, 2); run(1'b1, 2); run(1'b0, 10);
    check("bnc_pulses", n_pulse, 1);
    check("bnc_vld", n_vld, 1);
    check("bnc_glitch", n_glitch, 0);
    check("bnc_width", last_width, 10);
    // Re-armed: a fresh pulse qualifies
    clear_counts();
    run(1'b1, 6); run(1'b0, 10);
    check("bnc_rearm", n_pulse, 1);

    // Back-to-back at minimum period
    clear_counts();
    run(1'b1, 5); run(1'b0, 4); run(1'b1, 5); run(1'b0, 10);
    check("b2b_pulses", n_pulse, 2);
    check("b2b_vld", n_vld, 2);
    check("b2b_width", last_width, 5);

    // Reset mid-pulse
    run(1'b1, 10);
    clear_counts();
    cycle(1'b1, 1'b1);
    check("rst_outs", int'(pulse_out) + int'(glitch) + int'(width_vld), 0);
    check("rst_width", int'(width), 0);
    t0 = cyc; run(1'b1, 10);
    check("rst_vld_none", n_vld, 0);
    check("rst_rise_lat", last_pulse_cyc - t0, 6);
    run(1'b0, 15);
    check("rst_pulses", n_pulse, 1);
    check("rst_width_new", last_width, 10);

    // Randomized run lengths with occasional resets
    lvl = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) cycle(1'b0, 1'b1);
      lvl = ~lvl;
      run(lvl, int'($urandom_range(1, 12)));
    end
    run(1'b0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
